// File: rtl/seq_priority_encoder_pkg.sv
// Shared types and width helpers for the sequential priority encoder.
package seq_priority_encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int unsigned enc_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_N = 8;
    localparam int unsigned DEF_W = enc_w(DEF_N);

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request lines plus the valid/ready code stream of the sequential encoder.
interface seq_priority_encoder_if
    import seq_priority_encoder_pkg::*;
#(
    parameter int unsigned N = DEF_N
);
    localparam int unsigned W = enc_w(N);

    logic [N-1:0] in;
    logic [W-1:0] out_code;
    logic         out_valid;
    logic         out_ready;
    logic         ovf;

    modport master (
        input  in,
        input  out_ready,
        output out_code,
        output out_valid,
        output ovf
    );

    modport slave (
        output in,
        output out_ready,
        input  out_code,
        input  out_valid,
        input  ovf
    );

endinterface

// File: rtl/seq_priority_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit encoder; idx is 0 when no bit is set.
module prio_enc_lsb
    import seq_priority_encoder_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    localparam int unsigned W = enc_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// Captures rising edges on N request lines and emits their indices lowest-first
// over a valid/ready handshake; ovf flags an edge that hit a still-pending line.
module seq_priority_encoder
    import seq_priority_encoder_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_priority_encoder_if.master  bus
);

    localparam int unsigned W = enc_w(N);

    state_e       state_q, state_d;
    logic [N-1:0] in_q;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [W-1:0] sel;
    logic         any_pending;
    logic         load;

    assign rise = bus.in & ~in_q;

    prio_enc_lsb #(
        .N (N)
    ) u_sel (
        .vec (pending_q),
        .idx (sel),
        .any (any_pending)
    );

    // The presented code's bit was cleared when it was loaded, so pending_q
    // already excludes it when HOLD decides whether to chain the next code.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    load    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    if (any_pending) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        clr       = load ? (N'(1) << sel) : '0;
        // A rise on the bit being cleared is a fresh event and survives.
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = ovf_q | (|(rise & pending_q & ~clr));
        code_d    = load ? sel : code_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_q      <= bus.in;
            pending_q <= '0;
            code_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_q      <= bus.in;
            pending_q <= pending_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.out_code  = code_q;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: event-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_seq_priority_encoder;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic clk = 1'b0;
    logic rst;

    seq_priority_encoder_if #(.N(N)) bus ();

    seq_priority_encoder #(
        .N (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of outstanding events and one presented slot.
    logic [N-1:0] m_prev;
    bit           m_pend [N];
    bit           m_valid;
    int           m_code;
    bit           m_ovf;

    always @(posedge clk) begin
        logic [N-1:0] cur;
        bit           found;
        cur = bus.in;
        if (rst) begin
            m_prev  = cur;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 0;
            m_ovf   = 1'b0;
        end else begin
            if (!m_valid || bus.out_ready) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i]) begin
                        found     = 1'b1;
                        m_code    = i;
                        m_pend[i] = 1'b0;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < N; i++) begin
                if (cur[i] && !m_prev[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
            m_prev = cur;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
            if (m_valid) chk("model_code", 32'(bus.out_code), 32'(m_code));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in        = 8'h05;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Lines high through reset produce no events.
        chk("rst_code", 32'(bus.out_code), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("held_high_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("held_high_ovf", 32'(bus.ovf), 32'd0);

        // Two bits together, ready high: codes 2 then 5 back-to-back.
        bus.in        = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in = 8'h24;
        @(negedge clk);
        chk("two_lat1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("two_first_valid", 32'(bus.out_valid), 32'd1);
        chk("two_first_code", 32'(bus.out_code), 32'd2);
        @(negedge clk);
        chk("two_second_valid", 32'(bus.out_valid), 32'd1);
        chk("two_second_code", 32'(bus.out_code), 32'd5);
        @(negedge clk);
        chk("two_done_valid", 32'(bus.out_valid), 32'd0);
        bus.in = 8'h00;
        idle_cycles(2);

        // Bit 7 held under back-pressure.
        bus.out_ready = 1'b0;
        bus.in        = 8'h80;
        @(negedge clk);
        bus.in = 8'h00;
        chk("bp_lat1_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_code", 32'(bus.out_code), 32'd7);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
        idle_cycles(2);

        // Re-trigger of a still-pending bit sets ovf; only one code 3.
        bus.out_ready = 1'b0;
        bus.in        = 8'h0a;
        @(negedge clk);
        bus.in = 8'h00;
        @(negedge clk);
        chk("ovf_present_code", 32'(bus.out_code), 32'd1);
        bus.in = 8'h08;
        @(negedge clk);
        bus.in = 8'h00;
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("ovf_code3", 32'(bus.out_code), 32'd3);
        @(negedge clk);
        chk("ovf_single3_valid", 32'(bus.out_valid), 32'd0);
        idle_cycles(3);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);

        // Bit 4 re-rises on the edge that accepts it: a second code 4, no ovf.
        bus.out_ready = 1'b0;
        bus.in        = 8'h10;
        @(negedge clk);
        bus.in = 8'h00;
        @(negedge clk);
        chk("rerise_first_code", 32'(bus.out_code), 32'd4);
        bus.out_ready = 1'b1;
        bus.in        = 8'h10;
        @(negedge clk);
        chk("rerise_gap_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("rerise_second_valid", 32'(bus.out_valid), 32'd1);
        chk("rerise_second_code", 32'(bus.out_code), 32'd4);
        chk("rerise_no_ovf", 32'(bus.ovf), 32'd0);
        bus.in = 8'h00;
        idle_cycles(2);

        // Reset mid-operation discards presented and pending events.
        bus.out_ready = 1'b0;
        bus.in        = 8'h40;
        @(negedge clk);
        bus.in = 8'h03;
        @(negedge clk);
        chk("rstmid_code", 32'(bus.out_code), 32'd6);
        bus.in = 8'h00;
        do_reset();
        chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstmid_quiet", 32'(bus.out_valid), 32'd0);
        end

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bus.in        = N'($urandom & $urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst           = 1'b0;
        bus.in        = 8'h00;
        bus.out_ready = 1'b1;
        idle_cycles(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
